// File: rtl/game_flow_ctrl_pkg.sv
// Shared types for the game-flow controller: game state and difficulty phase encodings.
package game_flow_ctrl_pkg;

   typedef enum logic [2:0] {
      GameIdle    = 3'd0,
      GamePlaying = 3'd1,
      GameVictory = 3'd2,
      GameDefeat  = 3'd3,
      GameError   = 3'd4
   } game_state_e;

   typedef enum logic [1:0] {
      Phase1 = 2'd0,
      Phase2 = 2'd1,
      Phase3 = 2'd2,
      Phase4 = 2'd3
   } phase_e;

   // Phase only ratchets upward within a game.
   function automatic phase_e phase_max(phase_e cur, phase_e tgt);
      return (tgt > cur) ? tgt : cur;
   endfunction

endpackage

// File: rtl/game_flow_ctrl_popcount.sv
// Combinational count of set enemy-alive flags.
module game_flow_ctrl_popcount #(
   parameter int unsigned NUM_ENEMY = 16,
   parameter int unsigned CNT_W     = $clog2(NUM_ENEMY + 1)
) (
   input  logic [NUM_ENEMY-1:0] alive,
   output logic [CNT_W-1:0]     count
);

   always_comb begin
      count = '0;
      for (int i = 0; i < NUM_ENEMY; i++) begin
         count = count + CNT_W'(alive[i]);
      end
   end

endmodule

// File: rtl/game_flow_ctrl.sv
// Game-flow controller: game state, lives with post-hit invulnerability, alive count and
// monotonic difficulty phase.
module game_flow_ctrl
   import game_flow_ctrl_pkg::*;
#(
   parameter int unsigned NUM_ENEMY     = 16,
   parameter int unsigned LIVES         = 3,
   parameter int unsigned INVULN_FRAMES = 60,
   parameter int unsigned PH2_ALIVE     = 12,
   parameter int unsigned PH3_ALIVE     = 8,
   parameter int unsigned PH4_ALIVE     = 4,
   localparam int unsigned CNT_W        = $clog2(NUM_ENEMY + 1),
   localparam int unsigned LIFE_W       = $clog2(LIVES + 1),
   localparam int unsigned INV_W        = $clog2(INVULN_FRAMES + 1)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start_i,
   input  logic                 frame_tick_i,
   input  logic [NUM_ENEMY-1:0] enemy_alive_i,
   input  logic                 player_hit_i,
   output logic [2:0]           game_state_o,
   output logic [1:0]           phase_o,
   output logic [LIFE_W-1:0]    lives_o,
   output logic [CNT_W-1:0]     alive_cnt_o,
   output logic                 invuln_o,
   output logic                 spawn_o
);

   game_state_e      state;
   phase_e           phase;
   phase_e           target;
   logic             armed;
   logic [CNT_W-1:0] pop_cnt;
   logic [CNT_W-1:0] prev_cnt;
   logic [INV_W-1:0] inv_cnt;
   logic             playing, hit_ok, fatal, resurrect, cleared;

   game_flow_ctrl_popcount #(
      .NUM_ENEMY (NUM_ENEMY),
      .CNT_W     (CNT_W)
   ) u_popcount (
      .alive (enemy_alive_i),
      .count (pop_cnt)
   );

   assign playing   = (state == GamePlaying);
   assign hit_ok    = playing && player_hit_i && !invuln_o;
   assign fatal     = hit_ok && (lives_o == LIFE_W'(1));
   assign resurrect = playing && armed && (alive_cnt_o > prev_cnt);
   assign cleared   = playing && armed && (alive_cnt_o == '0);

   always_comb begin
      target = Phase1;
      if (alive_cnt_o <= CNT_W'(PH4_ALIVE))      target = Phase4;
      else if (alive_cnt_o <= CNT_W'(PH3_ALIVE)) target = Phase3;
      else if (alive_cnt_o <= CNT_W'(PH2_ALIVE)) target = Phase2;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= GameIdle;
         phase       <= Phase1;
         lives_o     <= '0;
         alive_cnt_o <= '0;
         prev_cnt    <= '0;
         armed       <= 1'b0;
         spawn_o     <= 1'b0;
      end else begin
         alive_cnt_o <= pop_cnt;
         prev_cnt    <= alive_cnt_o;
         spawn_o     <= 1'b0;
         unique case (state)
            GameIdle: begin
               if (start_i) begin
                  state   <= GamePlaying;
                  spawn_o <= 1'b1;
                  lives_o <= LIFE_W'(LIVES);
                  phase   <= Phase1;
                  armed   <= 1'b0;
               end
            end
            GamePlaying: begin
               if (alive_cnt_o == CNT_W'(NUM_ENEMY)) armed <= 1'b1;
               if (armed) phase <= phase_max(phase, target);
               if (resurrect) begin
                  state <= GameError;
               end else begin
                  if (hit_ok) lives_o <= lives_o - LIFE_W'(1);
                  if (fatal) state <= GameDefeat;
                  else if (cleared) state <= GameVictory;
               end
            end
            default: begin
               if (start_i) state <= GameIdle;
            end
         endcase
      end
   end

   // A hit reloads the full window even when a frame tick lands on the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         invuln_o <= 1'b0;
         inv_cnt  <= '0;
      end else if (!playing || resurrect || fatal || cleared) begin
         invuln_o <= 1'b0;
         inv_cnt  <= '0;
      end else if (hit_ok) begin
         invuln_o <= 1'b1;
         inv_cnt  <= INV_W'(INVULN_FRAMES);
      end else if (invuln_o && frame_tick_i) begin
         inv_cnt <= inv_cnt - INV_W'(1);
         if (inv_cnt == INV_W'(1)) invuln_o <= 1'b0;
      end
   end

   assign game_state_o = state;
   assign phase_o      = phase;

endmodule
